// File: rtl/bist_engine_param.sv
// Self-sequencing BIST wrapper: two LFSRs drive key/data into the core, a MISR
// compacts the core output, and the final signature is checked against a golden value.
module bist_engine_param #(
   parameter int               WIDTH        = 8,
   parameter int               NUM_PATTERNS = 64,
   parameter int               DRAIN_CYCLES = 32,
   parameter logic [WIDTH-1:0] LFSR_TAPS    = 8'h63,
   parameter logic [WIDTH-1:0] MISR_TAPS    = 8'h63,
   parameter logic [WIDTH-1:0] KEY_SEED     = 8'hA5,
   parameter logic [WIDTH-1:0] DATA_SEED    = 8'h0F,
   parameter logic [WIDTH-1:0] GOLDEN_SIG   = 8'hC0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bist_mode,
   input  logic             start,
   input  logic [WIDTH-1:0] key_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic [WIDTH-1:0] dut_out,
   input  logic             dut_vld,
   output logic [WIDTH-1:0] key_to_dut,
   output logic [WIDTH-1:0] d_to_dut,
   output logic             pat_vld,
   output logic [WIDTH-1:0] d_out,
   output logic [WIDTH-1:0] sig,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   localparam int MAX_CNT = (NUM_PATTERNS > DRAIN_CYCLES) ? NUM_PATTERNS : DRAIN_CYCLES;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] LAST_PAT   = CW'(NUM_PATTERNS - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRIVE,
      S_DRAIN,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_key;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_sig;
   logic             r_done;
   logic             r_pass;
   logic             w_busy;
   logic             w_abort;
   logic             w_compact;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (bist_mode && start) w_next = S_LOAD;
         S_LOAD:    w_next = bist_mode ? S_DRIVE : S_IDLE;
         S_DRIVE: begin
            if (!bist_mode)             w_next = S_IDLE;
            else if (r_cnt == LAST_PAT) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (!bist_mode)               w_next = S_IDLE;
            else if (r_cnt == LAST_DRAIN) w_next = S_COMPARE;
         end
         S_COMPARE: w_next = bist_mode ? S_DONE : S_IDLE;
         S_DONE: begin
            if (!bist_mode) w_next = S_IDLE;
            else if (start) w_next = S_LOAD;
         end
         default:   w_next = S_IDLE;
      endcase
   end

   assign w_busy    = (r_state == S_LOAD) || (r_state == S_DRIVE) ||
                      (r_state == S_DRAIN) || (r_state == S_COMPARE);
   assign w_abort   = w_busy && !bist_mode;
   assign w_compact = !w_abort && dut_vld && ((r_state == S_DRIVE) || (r_state == S_DRAIN));

   // An abort clears the verdict but freezes the LFSRs and signature where they stand.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_key  <= KEY_SEED;
         r_data <= DATA_SEED;
         r_sig  <= '0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else if (w_abort) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else begin
         if (w_compact) begin
            r_sig <= {r_sig[WIDTH-2:0], ^(r_sig & MISR_TAPS)} ^ dut_out;
         end
         case (r_state)
            S_LOAD: begin
               r_key  <= KEY_SEED;
               r_data <= DATA_SEED;
               r_sig  <= '0;
               r_cnt  <= '0;
               r_done <= 1'b0;
               r_pass <= 1'b0;
            end
            S_DRIVE: begin
               r_key  <= {r_key[WIDTH-2:0], ^(r_key & LFSR_TAPS)};
               r_data <= {r_data[WIDTH-2:0], ^(r_data & LFSR_TAPS)};
               r_cnt  <= (r_cnt == LAST_PAT) ? '0 : r_cnt + 1'b1;
            end
            S_DRAIN: begin
               r_cnt <= (r_cnt == LAST_DRAIN) ? '0 : r_cnt + 1'b1;
            end
            S_COMPARE: begin
               r_pass <= (r_sig == GOLDEN_SIG);
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign key_to_dut = bist_mode ? r_key  : key_in;
   assign d_to_dut   = bist_mode ? r_data : d_in;
   assign d_out      = bist_mode ? r_sig  : dut_out;
   assign sig        = r_sig;
   assign pat_vld    = (r_state == S_DRIVE);
   assign busy       = w_busy;
   assign done       = r_done;
   assign pass       = r_pass;

endmodule

// File: tb/tb_bist_engine_param.sv
// Directed bench for bist_engine_param: pass-through vectors, full BIST runs,
// signature mismatch, abort/restart, start-while-busy and asynchronous reset.
module tb_bist_engine_param;

   localparam int NP = 64;
   localparam int ND = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bist_mode = 1'b0;
   logic       start = 1'b0;
   logic       dut_vld = 1'b0;
   logic [7:0] key_in = '0;
   logic [7:0] d_in = '0;
   logic [7:0] dut_out = '0;
   logic [7:0] key_to_dut;
   logic [7:0] d_to_dut;
   logic [7:0] d_out;
   logic [7:0] sig;
   logic       pat_vld;
   logic       busy;
   logic       done;
   logic       pass;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic       mode;
      logic [7:0] key;
      logic [7:0] dat;
      logic [7:0] core;
      logic [7:0] expKey;
      logic [7:0] expDat;
      logic [7:0] expOut;
   } vec_t;

   vec_t vecs [0:5];

   bist_engine_param #(
      .WIDTH(8), .NUM_PATTERNS(NP), .DRAIN_CYCLES(ND),
      .LFSR_TAPS(8'h63), .MISR_TAPS(8'h63),
      .KEY_SEED(8'hA5), .DATA_SEED(8'h0F), .GOLDEN_SIG(8'h00)
   ) dut (
      .clk(clk), .rst(rst), .bist_mode(bist_mode), .start(start),
      .key_in(key_in), .d_in(d_in), .dut_out(dut_out), .dut_vld(dut_vld),
      .key_to_dut(key_to_dut), .d_to_dut(d_to_dut), .pat_vld(pat_vld),
      .d_out(d_out), .sig(sig), .busy(busy), .done(done), .pass(pass)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lfsrNext(input logic [7:0] q);
      return {q[6:0], ^(q & 8'h63)};
   endfunction

   function automatic logic [7:0] misrNext(input logic [7:0] s, input logic [7:0] din);
      return {s[6:0], ^(s & 8'h63)} ^ din;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bist_mode = v.mode;
      key_in    = v.key;
      d_in      = v.dat;
      dut_out   = v.core;
   endtask

   // Pulses start, then walks edges after the start edge until done rises.
   task automatic doRun(input int pulseCyc, input logic [7:0] pulseVal, input int startCyc,
                        input bit checkPat, output int doneEdge, output int patCount);
      logic [7:0] expKey;
      logic [7:0] expDat;
      logic [7:0] handKey [0:3];
      logic [7:0] handDat [0:2];
      handKey  = '{8'hA5, 8'h4A, 8'h94, 8'h28};
      handDat  = '{8'h0F, 8'h1E, 8'h3D};
      expKey   = 8'hA5;
      expDat   = 8'h0F;
      doneEdge = -1;
      patCount = 0;
      dut_out  = 8'h00;
      start    = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("load_busy", busy, 1);
      checkOutput("load_pat_vld", pat_vld, 0);
      for (int k = 1; k <= 150; k++) begin
         tick();
         if (pat_vld) patCount++;
         if (k == 1) checkOutput("run_done_cleared", done, 0);
         if (checkPat && k <= NP) begin
            if (k <= 4) checkOutput("hand_key", key_to_dut, handKey[k-1]);
            if (k <= 3) checkOutput("hand_data", d_to_dut, handDat[k-1]);
            checkOutput("lfsr_key", key_to_dut, expKey);
            checkOutput("lfsr_data", d_to_dut, expDat);
            expKey = lfsrNext(expKey);
            expDat = lfsrNext(expDat);
         end
         dut_out = (k == pulseCyc) ? pulseVal : 8'h00;
         start   = (k == startCyc);
         if (done) begin
            doneEdge = k;
            break;
         end
      end
      start   = 1'b0;
      dut_out = 8'h00;
   endtask

   initial begin
      int         doneEdge;
      int         patCount;
      logic [7:0] expSig;

      vecs[0] = '{1'b0, 8'h3C, 8'h5A, 8'h77, 8'h3C, 8'h5A, 8'h77};
      vecs[1] = '{1'b0, 8'hFF, 8'h00, 8'hA5, 8'hFF, 8'h00, 8'hA5};
      vecs[2] = '{1'b1, 8'h3C, 8'h5A, 8'h77, 8'hA5, 8'h0F, 8'h00};
      vecs[3] = '{1'b0, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56};
      vecs[4] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'h0F, 8'h00};
      vecs[5] = '{1'b0, 8'h00, 8'hFF, 8'h80, 8'h00, 8'hFF, 8'h80};

      #12;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_pass", pass, 0);
      checkOutput("reset_pat_vld", pat_vld, 0);
      checkOutput("reset_sig", sig, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Combinational muxes in IDLE with seeds loaded and sig cleared.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput("vec_key_to_dut", key_to_dut, vecs[i].expKey);
         checkOutput("vec_d_to_dut", d_to_dut, vecs[i].expDat);
         checkOutput("vec_d_out", d_out, vecs[i].expOut);
         tick();
         checkOutput("vec_busy", busy, 0);
      end

      bist_mode = 1'b1;
      dut_vld   = 1'b1;
      dut_out   = 8'h5A;
      tick();
      tick();
      checkOutput("idle_no_compact", sig, 8'h00);

      bist_mode = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checkOutput("start_ignored_functional", busy, 0);

      // Golden run: all-zero core output keeps the signature at zero.
      bist_mode = 1'b1;
      dut_vld   = 1'b1;
      doRun(0, 8'h00, 0, 1'b1, doneEdge, patCount);
      checkOutput("golden_done_edge", doneEdge, NP + ND + 2);
      checkOutput("golden_pat_count", patCount, NP);
      checkOutput("golden_pass", pass, 1);
      checkOutput("golden_sig", sig, 8'h00);
      checkOutput("golden_d_out", d_out, 8'h00);
      checkOutput("golden_busy", busy, 0);

      dut_out = 8'h55;
      tick();
      checkOutput("done_no_compact", sig, 8'h00);
      bist_mode = 1'b0;
      #1;
      checkOutput("mux_toggle_d_out", d_out, 8'h55);
      tick();
      checkOutput("idle_done_retained", done, 1);
      checkOutput("idle_pass_retained", pass, 1);
      checkOutput("idle_busy", busy, 0);

      // Mismatch: 01 in the second-to-last DRAIN cycle shifts once more to 03.
      bist_mode = 1'b1;
      doRun(NP + ND - 1, 8'h01, 0, 1'b0, doneEdge, patCount);
      checkOutput("mismatch_done_edge", doneEdge, NP + ND + 2);
      checkOutput("mismatch_sig", sig, 8'h03);
      checkOutput("mismatch_pass", pass, 0);
      checkOutput("mismatch_done", done, 1);

      // Abort at DRIVE cycle 10 with 01 compacted on each prior DRIVE edge.
      dut_out = 8'h01;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      expSig = 8'h00;
      for (int i = 0; i < 9; i++) expSig = misrNext(expSig, 8'h01);
      checkOutput("abort_pre_pat_vld", pat_vld, 1);
      checkOutput("abort_pre_sig", sig, expSig);
      bist_mode = 1'b0;
      tick();
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_pass", pass, 0);
      checkOutput("abort_pat_vld", pat_vld, 0);
      checkOutput("abort_sig_hold", sig, expSig);

      // Restart with a stray start in DRAIN; completion edge must not move.
      bist_mode = 1'b1;
      dut_vld   = 1'b0;
      doRun(0, 8'h00, NP + 16, 1'b1, doneEdge, patCount);
      checkOutput("restart_done_edge", doneEdge, NP + ND + 2);
      checkOutput("restart_pat_count", patCount, NP);
      checkOutput("restart_pass", pass, 1);

      // Asynchronous reset in the middle of DRIVE.
      dut_vld = 1'b1;
      dut_out = 8'h01;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      expSig = 8'h00;
      for (int i = 0; i < 4; i++) expSig = misrNext(expSig, 8'h01);
      checkOutput("areset_pre_sig", sig, expSig);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("areset_pat_vld", pat_vld, 0);
      checkOutput("areset_busy", busy, 0);
      checkOutput("areset_sig", sig, 8'h00);
      checkOutput("areset_done", done, 0);
      checkOutput("areset_key", key_to_dut, 8'hA5);
      @(negedge clk);
      rst = 1'b1;
      tick();
      checkOutput("post_reset_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/bist_engine_param.md
Name: bist_engine_param

Overview:
- Parametrised, self-sequencing BIST engine that sits between the system inputs and an N-bit-datapath crypto core (AES-128 8-bit-path class).
- Generates key and data pseudo-random streams from two LFSRs and compacts the core's output into a MISR.
- Runs a fixed pattern count followed by a drain window, then compares the signature against a golden value and reports pass/fail.
- In functional mode, key, data and output pass straight through the block.

Parameters:
- WIDTH, 8: datapath width of key, data, LFSRs and MISR (≥2).
- NUM_PATTERNS, 64: pattern cycles driven in DRIVE (≥1).
- DRAIN_CYCLES, 32: cycles spent in DRAIN after DRIVE (≥1).
- LFSR_TAPS, 8'h63: feedback tap mask shared by both LFSRs (WIDTH bits).
- MISR_TAPS, 8'h63: MISR feedback tap mask (WIDTH bits).
- KEY_SEED, 8'hA5: key LFSR seed. Must be non-zero.
- DATA_SEED, 8'h0F: data LFSR seed. Must be non-zero.
- GOLDEN_SIG, 8'hC0: expected final signature.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- bist_mode  in  1  1 = BIST muxing and engine enabled; 0 = functional pass-through.
- start  in  1  single-cycle request to begin a run.
- key_in  in  WIDTH  functional key byte.
- d_in  in  WIDTH  functional data byte.
- dut_out  in  WIDTH  core output.
- dut_vld  in  1  core output valid.
- key_to_dut  out  WIDTH  bist_mode ? key LFSR : key_in.
- d_to_dut  out  WIDTH  bist_mode ? data LFSR : d_in.
- pat_vld  out  1  high while the state is DRIVE.
- d_out  out  WIDTH  bist_mode ? sig : dut_out.
- sig  out  WIDTH  current MISR value.
- busy  out  1  high in LOAD, DRIVE, DRAIN and COMPARE.
- done  out  1  run complete; held high.
- pass  out  1  valid when done=1; held high.

Behaviour:
Reset (rst=0):
- State = IDLE.
- Key LFSR = KEY_SEED; data LFSR = DATA_SEED.
- sig = 0; counters = 0.
- pat_vld = busy = done = pass = 0.

LFSR (Fibonacci):
- Next value = {q[WIDTH-2:0], ^(q & LFSR_TAPS)}.
- Advances only on DRIVE cycles; holds otherwise.

MISR:
- Next value = {sig[WIDTH-2:0], ^(sig & MISR_TAPS)} ^ dut_out.
- Updates only when dut_vld=1 and the state is DRIVE or DRAIN; holds otherwise.

Counters:
- Width is $clog2(max(NUM_PATTERNS, DRAIN_CYCLES)+1).

FSM:
- IDLE: on start=1 with bist_mode=1 → LOAD. start with bist_mode=0 is ignored.
- LOAD (1 cycle): reload both seeds, sig=0, counter=0, done=0, pass=0 → DRIVE.
- DRIVE: pat_vld=1. The first pattern presented is the seed pair. After NUM_PATTERNS cycles → DRAIN.
- DRAIN: pat_vld=0. After DRAIN_CYCLES cycles → COMPARE.
- COMPARE (1 cycle): pass ≤ (sig == GOLDEN_SIG); done ≤ 1 → DONE.
- DONE: done and pass held.
  - start=1 (bist_mode=1) → LOAD.
  - bist_mode=0 → IDLE; done and pass are retained until the next LOAD.

Latency:
- With start sampled at edge 0, done rises at edge NUM_PATTERNS+DRAIN_CYCLES+2.
- Defaults: 98 cycles.

Boundary conditions:
- start while busy: ignored. No restart or extension of the run.
- bist_mode dropping in LOAD, DRIVE, DRAIN or COMPARE (abort): → IDLE next edge; busy=0, done=0, pass=0, pat_vld=0. sig holds.
- dut_vld=1 in IDLE or DONE: MISR does not update.
- dut_vld=1 on the last DRIVE cycle and in DRAIN: compacted.
- Mid-run async reset: all outputs return to reset values immediately, not waiting for the clock edge.
- Output muxes are combinational on bist_mode. A toggle takes effect the same cycle.

Test Plan:
- Reset then pass-through: bist_mode=0, key_in=8'h3C, d_in=8'h5A, dut_out=8'h77 → key_to_dut=3C, d_to_dut=5A, d_out=77; busy=done=pass=0.
- LFSR sequence: bist_mode=1, pulse start → during DRIVE, key_to_dut = A5, 4A, 94, 28… and d_to_dut = 0F, 1E, 3D…; pat_vld high for exactly 64 cycles.
- Golden match: dut_out=8'h00, dut_vld=1 throughout, GOLDEN_SIG=8'h00 → done rises 98 cycles after the start edge; pass=1; sig=00; d_out=00.
- Golden mismatch: a single dut_vld pulse with dut_out=8'h01 in DRAIN, GOLDEN_SIG=8'h00 → sig at COMPARE is the shifted image of 01 (01 if the pulse is in the last DRAIN cycle); pass=0, done=1.
- Abort and restart: drop bist_mode at DRIVE cycle 10 → IDLE next edge, busy=0, done=0. Re-assert bist_mode and pulse start → the first pattern is A5/0F again and the full run completes.
- start during busy plus async reset: a start pulse in DRAIN leaves the completion edge unchanged. rst=0 asserted mid-DRIVE → pat_vld, busy and sig are 0 before the next clock edge.
